// File: rtl/gpio_irq.sv
// Parametrised GPIO peripheral: per-pin mode, synchronised inputs, output drive,
// and per-pin edge interrupts with W1C status and a registered level IRQ.
module gpio_irq #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  input  logic [NUM_PINS-1:0] io_pin_i,
  output logic [NUM_PINS-1:0] io_pin_o,
  output logic [NUM_PINS-1:0] io_oe_o,
  output logic                irq_o
);

  localparam logic [4:0] ADDR_CTRL = 5'h00;
  localparam logic [4:0] ADDR_DATA = 5'h04;
  localparam logic [4:0] ADDR_EN   = 5'h08;
  localparam logic [4:0] ADDR_POL  = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;

  logic [2*NUM_PINS-1:0] ctrl_q, ctrl_d;
  logic [NUM_PINS-1:0]   data_q, data_d;
  logic [NUM_PINS-1:0]   en_q, en_d;
  logic [NUM_PINS-1:0]   pol_q, pol_d;
  logic [NUM_PINS-1:0]   stat_q, stat_d;
  logic [NUM_PINS-1:0]   hist_q;
  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
  logic                  irq_q, irq_d;

  logic [NUM_PINS-1:0]   pin_sync, in_mode, out_mode, edge_set;
  logic [4:0]            reg_addr;
  logic                  wr_ctrl, wr_data, wr_en, wr_pol, wr_stat;
  logic                  unused_bits;

  assign reg_addr    = addr_i[4:0];
  assign unused_bits = &{1'b0, addr_i[31:5], data_i};
  assign wr_ctrl     = we_i && (reg_addr == ADDR_CTRL);
  assign wr_data     = we_i && (reg_addr == ADDR_DATA);
  assign wr_en       = we_i && (reg_addr == ADDR_EN);
  assign wr_pol      = we_i && (reg_addr == ADDR_POL);
  assign wr_stat     = we_i && (reg_addr == ADDR_STAT);
  assign pin_sync    = sync_q[SYNC_STAGES-1];

  // Reserved mode 11 decodes as neither input nor output, i.e. disabled.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      assign out_mode[gi] = (ctrl_q[2*gi +: 2] == 2'b01);
      assign in_mode[gi]  = (ctrl_q[2*gi +: 2] == 2'b10);
      assign edge_set[gi] = in_mode[gi] &
                            (pol_q[gi] ? (~pin_sync[gi] &  hist_q[gi])
                                       : ( pin_sync[gi] & ~hist_q[gi]));
    end
  endgenerate

  always_comb begin
    ctrl_d = ctrl_q;
    en_d   = en_q;
    pol_d  = pol_q;
    data_d = (data_q & ~in_mode) | (pin_sync & in_mode);
    stat_d = stat_q;
    if (wr_ctrl) ctrl_d = data_i[2*NUM_PINS-1:0];
    if (wr_data) data_d = data_i[NUM_PINS-1:0];
    if (wr_en)   en_d   = data_i[NUM_PINS-1:0];
    if (wr_pol)  pol_d  = data_i[NUM_PINS-1:0];
    if (wr_stat) stat_d = stat_q & ~data_i[NUM_PINS-1:0];
    // A new edge beats a simultaneous write-1-to-clear.
    stat_d = stat_d | edge_set;
    irq_d  = |(stat_q & en_q);
  end

  // History always tracks the synchronised value, so entering input mode
  // compares against a current sample and cannot flag a stale edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      data_q <= '0;
      en_q   <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      hist_q <= '0;
      sync_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      en_q   <= en_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      hist_q <= pin_sync;
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_pin_i};
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (reg_addr)
      ADDR_CTRL: data_o[2*NUM_PINS-1:0] = ctrl_q;
      ADDR_DATA: data_o[NUM_PINS-1:0]   = data_q;
      ADDR_EN:   data_o[NUM_PINS-1:0]   = en_q;
      ADDR_POL:  data_o[NUM_PINS-1:0]   = pol_q;
      ADDR_STAT: data_o[NUM_PINS-1:0]   = stat_q;
      default:   data_o = '0;
    endcase
  end

  assign io_oe_o  = out_mode;
  assign io_pin_o = data_q & out_mode;
  assign irq_o    = irq_q;

endmodule
